// File: rtl/uart_tx_out_unit.sv
// Output stage behind the core: buffers issued bytes in a small FIFO and serialises them as 8N1 UART.
// Back-pressure (out_stall) is a pure register decode so the core's hazard unit sees no path from out_issued.
module uart_tx_out_unit #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          out_issued,
    input  logic [31:0]                   out_data,
    output logic                          out_stall,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             unused_data_hi;

    assign unused_data_hi = ^out_data[31:8];

    assign full    = (count_q == DEPTH_C);
    assign push    = out_issued && !full;
    assign bit_end = (div_q == DIV_LAST);

    // NOTE: the byte store carries no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= out_data[7:0];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = bit_end ? '0 : div_q + DIV_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting: no idle gap.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    assign out_stall  = full;
    assign txd        = txd_q;
    assign tx_busy    = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_out_unit.sv
// Directed bench for uart_tx_out_unit (CLK_PER_BIT=4, FIFO_DEPTH=4); a line monitor decodes 8N1 frames.
module tb_uart_tx_out_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        out_issued;
    logic [31:0] out_data;
    logic        out_stall;
    logic        txd;
    logic        tx_busy;
    logic [2:0]  fifo_count;

    int tests_run;
    int tests_failed;

    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_err;
    int         ncyc;
    bit         m_active;
    int         m_pos;
    logic [7:0] m_byte;

    uart_tx_out_unit #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .out_issued(out_issued),
        .out_data  (out_data),
        .out_stall (out_stall),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line monitor: samples mid-bit on falling edges, aborts on reset.
    initial begin
        m_active  = 1'b0;
        m_pos     = 0;
        m_byte    = '0;
        frame_err = 0;
        ncyc      = 0;
        forever begin
            @(negedge clk);
            ncyc = ncyc + 1;
            if (!rst) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (txd === 1'b0) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    m_byte   = '0;
                    start_q.push_back(ncyc);
                end
            end else begin
                m_pos = m_pos + 1;
                if ((m_pos % CPB) == 2 && m_pos < 9 * CPB)
                    m_byte[(m_pos - CPB - 2) / CPB] = txd;
                if (m_pos == 9 * CPB + 2) begin
                    if (txd !== 1'b1) frame_err = frame_err + 1;
                    rx_q.push_back(m_byte);
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || m_active) && n < budget) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL %s_drain_timeout: still busy after %0d cycles, required idle", name, n);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        out_issued = 1'b1;
        out_data   = 32'hFFFF_FFFF;
        step();
        step();
        step();
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b want 1", txd); end
        tests_run++;
        if (out_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", out_stall); end
        tests_run++;
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        tests_run++;
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        out_issued = 1'b0;
        rst        = 1'b1;
        step();
        tests_run++;
        if (fifo_count !== 3'd0 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_push: count %0d busy %b want 0/0", fifo_count, tx_busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic       exp;
        int         bad;
        b   = 8'hA5;
        bad = 0;
        clear_mon();
        out_issued = 1'b1;
        out_data   = 32'h1234_56A5;
        step();
        out_issued = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd1 || txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_push: count %0d txd %b want 1/1", fifo_count, txd);
        end
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e <= 4)       exp = 1'b0;
            else if (e <= 36) exp = b[(e - 5) / 4];
            else              exp = 1'b1;
            tests_run++;
            if (txd !== exp) begin
                tests_failed++;
                bad++;
                if (bad < 5) $display("FAIL single_txd_edge%0d: got %b want %b", e, txd, exp);
            end
        end
        tests_run++;
        if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_edge40: got %b want 1", tx_busy); end
        step();
        tests_run++;
        if (tx_busy !== 1'b0 || txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_busy_edge41: busy %b txd %b want 0/1", tx_busy, txd);
        end
        step();
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_decode: got %0d bytes first %h want 1 byte a5", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            out_issued = 1'b1;
            out_data   = {24'h0, exp_b[i]};
            step();
        end
        out_issued = 1'b0;
        drain("b2b", 300);
        tests_run++;
        if (rx_q.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d frames want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (rx_q[i] !== exp_b[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                tests_run++;
                if (start_q[i] - start_q[i-1] != 10 * CPB) begin
                    tests_failed++;
                    $display("FAIL b2b_gap%0d: got %0d cycles want %0d", i, start_q[i] - start_q[i-1], 10 * CPB);
                end
            end
        end
    endtask

    task automatic test_full();
        int edge_n;
        int guard;
        int acc_edge[6];
        int exp_edge[6];
        exp_edge = '{0, 1, 2, 3, 4, 42};
        clear_mon();
        edge_n = 0;
        for (int i = 0; i < 6; i++) begin
            out_issued = 1'b1;
            out_data   = 32'(i + 1);
            if (i == 5) begin
                tests_run++;
                if (out_stall !== 1'b1 || fifo_count !== 3'd4) begin
                    tests_failed++;
                    $display("FAIL full_stall: stall %b count %0d want 1/4", out_stall, fifo_count);
                end
            end
            guard = 0;
            while (out_stall === 1'b1 && guard < 200) begin
                step();
                edge_n++;
                guard++;
            end
            step();
            acc_edge[i] = edge_n;
            edge_n++;
        end
        out_issued = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (acc_edge[i] != exp_edge[i]) begin
                tests_failed++;
                $display("FAIL full_accept%0d: got edge %0d want %0d", i + 1, acc_edge[i], exp_edge[i]);
            end
        end
        tests_run++;
        if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL full_refill: got %0d want 4", fifo_count); end
        drain("full", 400);
        tests_run++;
        if (rx_q.size() != 6) begin
            tests_failed++;
            $display("FAIL full_frames: got %0d want 6", rx_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (rx_q[i] !== 8'(i + 1)) begin
                    tests_failed++;
                    $display("FAIL full_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_b[4];
        exp_b = '{8'h3C, 8'hC3, 8'h96, 8'h69};
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            out_issued = 1'b1;
            out_data   = {24'h0, exp_b[i]};
            step();
        end
        out_issued = 1'b0;
        for (int e = 3; e <= 40; e++) step();
        tests_run++;
        if (fifo_count !== 3'd2) begin tests_failed++; $display("FAIL simul_pre: got %0d want 2", fifo_count); end
        out_issued = 1'b1;
        out_data   = {24'h0, exp_b[3]};
        step();
        out_issued = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd2 || txd !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_edge: count %0d txd %b want 2/0", fifo_count, txd);
        end
        drain("simul", 300);
        tests_run++;
        if (rx_q.size() != 4) begin
            tests_failed++;
            $display("FAIL simul_frames: got %0d want 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (rx_q[i] !== exp_b[i]) begin
                    tests_failed++;
                    $display("FAIL simul_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q_b[3];
        q_b = '{8'hF0, 8'h81, 8'h7E};
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            out_issued = 1'b1;
            out_data   = {24'h0, q_b[i]};
            step();
        end
        out_issued = 1'b0;
        for (int e = 3; e <= 18; e++) step();
        tests_run++;
        if (txd !== 1'b0 || fifo_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL midrst_pre: txd %b count %0d want 0/2", txd, fifo_count);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL midrst_txd: got %b want 1", txd); end
        tests_run++;
        if (fifo_count !== 3'd0 || tx_busy !== 1'b0 || out_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_state: count %0d busy %b stall %b want 0/0/0", fifo_count, tx_busy, out_stall);
        end
        step();
        step();
        rst = 1'b1;
        step();
        clear_mon();
        out_issued = 1'b1;
        out_data   = 32'h0000_005A;
        step();
        out_issued = 1'b0;
        drain("midrst", 200);
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL midrst_resume: got %0d bytes first %h want 1 byte 5a", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        out_issued   = 1'b0;
        out_data     = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_simultaneous();
        test_reset_mid_frame();
        tests_run++;
        if (frame_err != 0) begin
            tests_failed++;
            $display("FAIL stop_bits: got %0d bad stop bits want 0", frame_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
